// File: rtl/oled_task_scheduler.sv
// Frame-synchronous source scheduler for the OLED pixel stream: debounced, prioritised task select.
// Define OLED_SCHED_BLANK_EN to insert BLANK_FRAMES black frames between sources.
module oled_task_scheduler #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned BLANK_FRAMES    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  sw_task,
    input  logic        frame_begin,
    input  logic [15:0] colour_a,
    input  logic [15:0] colour_b,
    input  logic [15:0] colour_c,
    input  logic [15:0] colour_d,
    input  logic [15:0] colour_paint,
    output logic [15:0] pixel_data,
    output logic [3:0]  task_active,
    output logic        seg_en,
    output logic [2:0]  active_src,
    output logic        busy
);

    localparam int unsigned   CW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end
    if (BLANK_FRAMES < 1 || BLANK_FRAMES > 15) begin : g_bad_blank
        $error("BLANK_FRAMES must be in 1..15");
    end

    typedef enum logic [1:0] {
        SHOW,
        WAIT_FRAME,
        BLANK
    } state_t;

    logic [3:0]    sw_meta;
    logic [3:0]    sw_sync;
    logic [2:0]    fb_sync;
    logic          frame_tick;
    logic [2:0]    req;
    logic [2:0]    prev_req;
    logic [2:0]    stable_req;
    logic [CW-1:0] db_cnt;
    logic [CW-1:0] db_next;

    state_t        state;
    state_t        state_next;
    logic [2:0]    src_next;
    logic [2:0]    target;
    logic [2:0]    target_next;
    logic          blank_next;
    logic [15:0]   pix_next;
    logic [3:0]    task_next;
    logic          seg_next;
    logic          busy_next;

`ifdef OLED_SCHED_BLANK_EN
    localparam logic [3:0] BLANK_N = 4'(BLANK_FRAMES);
    logic [3:0] frame_cnt;
    logic [3:0] frame_cnt_next;
`endif

    // Input synchronisers; frame_tick is registered so it lands 3 cycles after the raw rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_meta    <= '0;
            sw_sync    <= '0;
            fb_sync    <= '0;
            frame_tick <= 1'b0;
        end else begin
            sw_meta    <= sw_task;
            sw_sync    <= sw_meta;
            fb_sync    <= {fb_sync[1:0], frame_begin};
            frame_tick <= fb_sync[1] & ~fb_sync[2];
        end
    end

    always_comb begin
        if (sw_sync[0])      req = 3'd1;
        else if (sw_sync[1]) req = 3'd2;
        else if (sw_sync[2]) req = 3'd3;
        else if (sw_sync[3]) req = 3'd4;
        else                 req = 3'd0;
    end

    // db_cnt holds the number of consecutive cycles req has been steady, saturating at DB_MAX.
    always_comb begin
        if (req != prev_req)      db_next = CW'(1);
        else if (db_cnt == DB_MAX) db_next = DB_MAX;
        else                       db_next = db_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_req   <= '0;
            db_cnt     <= '0;
            stable_req <= '0;
        end else begin
            prev_req <= req;
            db_cnt   <= db_next;
            if (db_next == DB_MAX)
                stable_req <= req;
        end
    end

    always_comb begin
        state_next  = state;
        src_next    = active_src;
        target_next = target;
`ifdef OLED_SCHED_BLANK_EN
        frame_cnt_next = frame_cnt;
`endif
        case (state)
            SHOW: begin
                if (stable_req != active_src) begin
                    state_next  = WAIT_FRAME;
                    target_next = stable_req;
                end
            end
            WAIT_FRAME: begin
                target_next = stable_req;
                if (stable_req == active_src) begin
                    state_next = SHOW;
                end else if (frame_tick) begin
`ifdef OLED_SCHED_BLANK_EN
                    state_next     = BLANK;
                    frame_cnt_next = '0;
`else
                    state_next = SHOW;
                    src_next   = target;
`endif
                end
            end
`ifdef OLED_SCHED_BLANK_EN
            BLANK: begin
                target_next = stable_req;
                if (frame_tick) begin
                    if (frame_cnt + 4'd1 == BLANK_N) begin
                        state_next     = SHOW;
                        src_next       = target;
                        frame_cnt_next = '0;
                    end else begin
                        frame_cnt_next = frame_cnt + 4'd1;
                    end
                end
            end
`endif
            default: state_next = SHOW;
        endcase
    end

    // Outputs are decoded from the next state/source so they change on the committing edge.
    always_comb begin
`ifdef OLED_SCHED_BLANK_EN
        blank_next = (state_next == BLANK);
`else
        blank_next = 1'b0;
`endif
        case (src_next)
            3'd0:    pix_next = colour_paint;
            3'd1:    pix_next = colour_a;
            3'd2:    pix_next = colour_b;
            3'd3:    pix_next = colour_c;
            3'd4:    pix_next = colour_d;
            default: pix_next = '0;
        endcase
        case (src_next)
            3'd1:    task_next = 4'b0001;
            3'd2:    task_next = 4'b0010;
            3'd3:    task_next = 4'b0100;
            3'd4:    task_next = 4'b1000;
            default: task_next = 4'b0000;
        endcase
        seg_next  = (src_next == 3'd0);
        busy_next = (state_next != SHOW);
        if (blank_next) begin
            pix_next  = '0;
            task_next = '0;
            seg_next  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= SHOW;
            active_src  <= '0;
            target      <= '0;
            pixel_data  <= '0;
            task_active <= '0;
            seg_en      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            active_src  <= src_next;
            target      <= target_next;
            pixel_data  <= pix_next;
            task_active <= task_next;
            seg_en      <= seg_next;
            busy        <= busy_next;
        end
    end

`ifdef OLED_SCHED_BLANK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            frame_cnt <= '0;
        else
            frame_cnt <= frame_cnt_next;
    end
`endif

endmodule

// File: tb/tb_oled_task_scheduler.sv
// Directed bench for oled_task_scheduler with DEBOUNCE_CYCLES=4, BLANK_FRAMES=2.
// Expectations follow OLED_SCHED_BLANK_EN so either build can be checked.
module tb_oled_task_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  sw_task = 4'b0000;
    logic        frame_begin = 1'b0;
    logic [15:0] colour_a = 16'h1111;
    logic [15:0] colour_b = 16'h2222;
    logic [15:0] colour_c = 16'h3333;
    logic [15:0] colour_d = 16'h4444;
    logic [15:0] colour_paint = 16'hF800;
    logic [15:0] pixel_data;
    logic [3:0]  task_active;
    logic        seg_en;
    logic [2:0]  active_src;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    oled_task_scheduler #(
        .DEBOUNCE_CYCLES(4),
        .BLANK_FRAMES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sw_task(sw_task),
        .frame_begin(frame_begin),
        .colour_a(colour_a),
        .colour_b(colour_b),
        .colour_c(colour_c),
        .colour_d(colour_d),
        .colour_paint(colour_paint),
        .pixel_data(pixel_data),
        .task_active(task_active),
        .seg_en(seg_en),
        .active_src(active_src),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Two-cycle strobe, then enough cycles for sync + tick + FSM edge to settle.
    task automatic frame_pulse();
        frame_begin = 1'b1;
        step(2);
        frame_begin = 1'b0;
        step(4);
    endtask

    task automatic test_reset();
        step(3);
        n_checks++; if (pixel_data !== 16'h0000) begin n_fail++; $display("FAIL reset_pixel: got %h want %h", pixel_data, 16'h0000); end
        n_checks++; if (task_active !== 4'b0000) begin n_fail++; $display("FAIL reset_task: got %b want %b", task_active, 4'b0000); end
        n_checks++; if (seg_en !== 1'b0) begin n_fail++; $display("FAIL reset_seg: got %b want %b", seg_en, 1'b0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want %b", busy, 1'b0); end
        n_checks++; if (active_src !== 3'd0) begin n_fail++; $display("FAIL reset_src: got %0d want %0d", active_src, 0); end
        reset = 1'b0;
        step(1);
        n_checks++; if (pixel_data !== 16'hF800) begin n_fail++; $display("FAIL first_pixel: got %h want %h", pixel_data, 16'hF800); end
        n_checks++; if (seg_en !== 1'b1) begin n_fail++; $display("FAIL first_seg: got %b want %b", seg_en, 1'b1); end
        n_checks++; if (task_active !== 4'b0000) begin n_fail++; $display("FAIL first_task: got %b want %b", task_active, 4'b0000); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL first_busy: got %b want %b", busy, 1'b0); end
        step(8);
    endtask

    task automatic test_switch_b();
        sw_task = 4'b0010;
        step(6);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL swb_busy_early: got %b want %b", busy, 1'b0); end
        step(1);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL swb_busy_7: got %b want %b", busy, 1'b1); end
        n_checks++; if (pixel_data !== 16'hF800) begin n_fail++; $display("FAIL swb_wait_pixel: got %h want %h", pixel_data, 16'hF800); end
        frame_pulse();
`ifdef OLED_SCHED_BLANK_EN
        n_checks++; if (pixel_data !== 16'h0000) begin n_fail++; $display("FAIL swb_blank1_pixel: got %h want %h", pixel_data, 16'h0000); end
        n_checks++; if (seg_en !== 1'b0) begin n_fail++; $display("FAIL swb_blank1_seg: got %b want %b", seg_en, 1'b0); end
        n_checks++; if (task_active !== 4'b0000) begin n_fail++; $display("FAIL swb_blank1_task: got %b want %b", task_active, 4'b0000); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL swb_blank1_busy: got %b want %b", busy, 1'b1); end
`else
        n_checks++; if (active_src !== 3'd2) begin n_fail++; $display("FAIL swb_nb_src: got %0d want %0d", active_src, 2); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL swb_nb_busy: got %b want %b", busy, 1'b0); end
`endif
        frame_pulse();
`ifdef OLED_SCHED_BLANK_EN
        n_checks++; if (pixel_data !== 16'h0000) begin n_fail++; $display("FAIL swb_blank2_pixel: got %h want %h", pixel_data, 16'h0000); end
        n_checks++; if (active_src !== 3'd0) begin n_fail++; $display("FAIL swb_blank2_src: got %0d want %0d", active_src, 0); end
`endif
        frame_pulse();
        n_checks++; if (active_src !== 3'd2) begin n_fail++; $display("FAIL swb_src: got %0d want %0d", active_src, 2); end
        n_checks++; if (task_active !== 4'b0010) begin n_fail++; $display("FAIL swb_task: got %b want %b", task_active, 4'b0010); end
        n_checks++; if (seg_en !== 1'b0) begin n_fail++; $display("FAIL swb_seg: got %b want %b", seg_en, 1'b0); end
        n_checks++; if (pixel_data !== 16'h2222) begin n_fail++; $display("FAIL swb_pixel: got %h want %h", pixel_data, 16'h2222); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL swb_busy_done: got %b want %b", busy, 1'b0); end
        colour_b = 16'h2A2A;
        step(1);
        n_checks++; if (pixel_data !== 16'h2A2A) begin n_fail++; $display("FAIL pixel_latency: got %h want %h", pixel_data, 16'h2A2A); end
        colour_b = 16'h2222;
        step(1);
    endtask

    task automatic test_priority();
        sw_task = 4'b0011;
        step(7);
        frame_pulse();
        frame_pulse();
        frame_pulse();
        n_checks++; if (active_src !== 3'd1) begin n_fail++; $display("FAIL prio_src: got %0d want %0d", active_src, 1); end
        n_checks++; if (task_active !== 4'b0001) begin n_fail++; $display("FAIL prio_task: got %b want %b", task_active, 4'b0001); end
        n_checks++; if (pixel_data !== 16'h1111) begin n_fail++; $display("FAIL prio_pixel: got %h want %h", pixel_data, 16'h1111); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL prio_busy: got %b want %b", busy, 1'b0); end
    endtask

    task automatic test_glitch();
        sw_task = 4'b1000;
        step(3);
        sw_task = 4'b0011;
        for (int i = 0; i < 12; i++) begin
            step(1);
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy[%0d]: got %b want %b", i, busy, 1'b0); end
        end
        n_checks++; if (active_src !== 3'd1) begin n_fail++; $display("FAIL glitch_src: got %0d want %0d", active_src, 1); end
        n_checks++; if (task_active !== 4'b0001) begin n_fail++; $display("FAIL glitch_task: got %b want %b", task_active, 4'b0001); end
        n_checks++; if (pixel_data !== 16'h1111) begin n_fail++; $display("FAIL glitch_pixel: got %h want %h", pixel_data, 16'h1111); end
    endtask

    task automatic test_retarget();
        sw_task = 4'b1000;
        step(7);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL retgt_busy_d: got %b want %b", busy, 1'b1); end
        frame_pulse();
`ifdef OLED_SCHED_BLANK_EN
        n_checks++; if (pixel_data !== 16'h0000) begin n_fail++; $display("FAIL retgt_blank_pixel: got %h want %h", pixel_data, 16'h0000); end
        n_checks++; if (active_src !== 3'd1) begin n_fail++; $display("FAIL retgt_blank_src: got %0d want %0d", active_src, 1); end
`else
        n_checks++; if (active_src !== 3'd4) begin n_fail++; $display("FAIL retgt_d_src: got %0d want %0d", active_src, 4); end
        n_checks++; if (pixel_data !== 16'h4444) begin n_fail++; $display("FAIL retgt_d_pixel: got %h want %h", pixel_data, 16'h4444); end
`endif
        sw_task = 4'b0100;
        step(8);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL retgt_busy_c: got %b want %b", busy, 1'b1); end
`ifdef OLED_SCHED_BLANK_EN
        n_checks++; if (pixel_data !== 16'h0000) begin n_fail++; $display("FAIL retgt_still_blank: got %h want %h", pixel_data, 16'h0000); end
        frame_pulse();
        n_checks++; if (pixel_data !== 16'h0000) begin n_fail++; $display("FAIL retgt_blank2_pixel: got %h want %h", pixel_data, 16'h0000); end
        frame_pulse();
`else
        frame_pulse();
`endif
        n_checks++; if (active_src !== 3'd3) begin n_fail++; $display("FAIL retgt_src: got %0d want %0d", active_src, 3); end
        n_checks++; if (task_active !== 4'b0100) begin n_fail++; $display("FAIL retgt_task: got %b want %b", task_active, 4'b0100); end
        n_checks++; if (pixel_data !== 16'h3333) begin n_fail++; $display("FAIL retgt_pixel: got %h want %h", pixel_data, 16'h3333); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL retgt_busy_done: got %b want %b", busy, 1'b0); end
    endtask

    task automatic test_cancel();
        sw_task = 4'b0010;
        step(7);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL cancel_busy_wait: got %b want %b", busy, 1'b1); end
        sw_task = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            step(1);
            n_checks++; if (pixel_data !== 16'h3333) begin n_fail++; $display("FAIL cancel_pixel[%0d]: got %h want %h", i, pixel_data, 16'h3333); end
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_busy: got %b want %b", busy, 1'b0); end
        frame_pulse();
        n_checks++; if (active_src !== 3'd3) begin n_fail++; $display("FAIL cancel_src: got %0d want %0d", active_src, 3); end
        n_checks++; if (pixel_data !== 16'h3333) begin n_fail++; $display("FAIL cancel_pixel_after: got %h want %h", pixel_data, 16'h3333); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_busy_after: got %b want %b", busy, 1'b0); end
    endtask

    task automatic test_reset_mid();
        sw_task = 4'b0001;
        step(7);
`ifdef OLED_SCHED_BLANK_EN
        frame_pulse();
        n_checks++; if (pixel_data !== 16'h0000) begin n_fail++; $display("FAIL rmid_in_blank: got %h want %h", pixel_data, 16'h0000); end
`endif
        reset = 1'b1;
        sw_task = 4'b0000;
        #1;
        n_checks++; if (pixel_data !== 16'h0000) begin n_fail++; $display("FAIL rmid_pixel: got %h want %h", pixel_data, 16'h0000); end
        n_checks++; if (task_active !== 4'b0000) begin n_fail++; $display("FAIL rmid_task: got %b want %b", task_active, 4'b0000); end
        n_checks++; if (seg_en !== 1'b0) begin n_fail++; $display("FAIL rmid_seg: got %b want %b", seg_en, 1'b0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want %b", busy, 1'b0); end
        n_checks++; if (active_src !== 3'd0) begin n_fail++; $display("FAIL rmid_src: got %0d want %0d", active_src, 0); end
        step(2);
        reset = 1'b0;
        step(1);
        n_checks++; if (pixel_data !== 16'hF800) begin n_fail++; $display("FAIL rmid_release_pixel: got %h want %h", pixel_data, 16'hF800); end
        n_checks++; if (seg_en !== 1'b1) begin n_fail++; $display("FAIL rmid_release_seg: got %b want %b", seg_en, 1'b1); end
        step(10);
        frame_pulse();
        n_checks++; if (active_src !== 3'd0) begin n_fail++; $display("FAIL rmid_discard_src: got %0d want %0d", active_src, 0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_discard_busy: got %b want %b", busy, 1'b0); end
        n_checks++; if (pixel_data !== 16'hF800) begin n_fail++; $display("FAIL rmid_discard_pixel: got %h want %h", pixel_data, 16'hF800); end
    endtask

    task automatic test_first_tick();
        sw_task = 4'b0001;
        step(7);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL tick_busy: got %b want %b", busy, 1'b1); end
        for (int i = 0; i < 6; i++) begin
            frame_begin = (i < 2);
            step(1);
`ifndef OLED_SCHED_BLANK_EN
            n_checks++; if (pixel_data === 16'h0000) begin n_fail++; $display("FAIL tick_zero_pixel[%0d]: got %h want nonzero", i, pixel_data); end
`endif
        end
        frame_begin = 1'b0;
`ifdef OLED_SCHED_BLANK_EN
        n_checks++; if (pixel_data !== 16'h0000) begin n_fail++; $display("FAIL tick_blank_pixel: got %h want %h", pixel_data, 16'h0000); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL tick_blank_busy: got %b want %b", busy, 1'b1); end
`else
        n_checks++; if (active_src !== 3'd1) begin n_fail++; $display("FAIL tick_src: got %0d want %0d", active_src, 1); end
        n_checks++; if (task_active !== 4'b0001) begin n_fail++; $display("FAIL tick_task: got %b want %b", task_active, 4'b0001); end
        n_checks++; if (pixel_data !== 16'h1111) begin n_fail++; $display("FAIL tick_pixel: got %h want %h", pixel_data, 16'h1111); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tick_busy_done: got %b want %b", busy, 1'b0); end
`endif
    endtask

    initial begin
        test_reset();
        test_switch_b();
        test_priority();
        test_glitch();
        test_retarget();
        test_cancel();
        test_reset_mid();
        test_first_tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
